// File: rtl/picture.sv
// ============================================================================
//  Module      : picture
//  Description : Row-scanning driver for an 8x8 red/green LED dot matrix.
//                Eight fixed patterns live in an internal ROM; the 3-bit
//                select P chooses which one is shown. One row is driven
//                per clock, so a full frame takes eight clocks.
//                Optional macro PICTURE_FRAME_LATCH_EN: when defined, the
//                pattern select is captured only at the start of a frame
//                so a frame never mixes two patterns.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module picture (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] P,
    output logic [7:0] hang,
    output logic [7:0] red,
    output logic [7:0] green
);

    // Row counter: the row that the next rising edge will put on the pins
    logic [2:0] r_scan;

    // Registered pin drivers so row select and column data switch together
    logic [7:0] r_hang;
    logic [7:0] r_red;
    logic [7:0] r_green;

    // Pattern actually used for the row being fetched this cycle
    logic [2:0] w_pat;

    // Current-row helpers and ROM lookup result
    logic [7:0] w_onehot;
    logic [7:0] w_mirror;
    logic [7:0] w_red;
    logic [7:0] w_green;

`ifdef PICTURE_FRAME_LATCH_EN
    // Pattern held for the remainder of the frame
    logic [2:0] r_pat;

    // Capture the select on the edge that shows row 0, hold it otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pat <= 3'd0;
        end else if (r_scan == 3'd0) begin
            r_pat <= P;
        end
    end

    // Row 0 already uses the freshly sampled select, later rows the held one
    assign w_pat = (r_scan == 3'd0) ? P : r_pat;
`else
    // Without frame latching the select goes straight into the ROM lookup
    assign w_pat = P;
`endif

    assign w_onehot = 8'h01 << r_scan;
    assign w_mirror = 8'h01 << (3'd7 - r_scan);

    // Pattern ROM: column data for the current row of the active pattern
    always_comb begin
        w_red   = 8'h00;
        w_green = 8'h00;
        case (w_pat)
            3'd0: begin
                w_red   = 8'h00;
                w_green = 8'h00;
            end
            3'd1: begin
                w_red   = 8'hFF;
                w_green = 8'h00;
            end
            3'd2: begin
                w_red   = 8'h00;
                w_green = 8'hFF;
            end
            3'd3: begin
                w_red   = 8'hFF;
                w_green = 8'hFF;
            end
            3'd4: begin
                // Border: solid top/bottom rows, end columns elsewhere
                w_red   = ((r_scan == 3'd0) || (r_scan == 3'd7)) ? 8'hFF : 8'h81;
                w_green = 8'h00;
            end
            3'd5: begin
                w_red   = w_onehot;
                w_green = 8'h00;
            end
            3'd6: begin
                // Checkerboard: colours swap phase on odd rows
                w_red   = r_scan[0] ? 8'h55 : 8'hAA;
                w_green = r_scan[0] ? 8'hAA : 8'h55;
            end
            3'd7: begin
                // Red X from both diagonals, green plus through the centre
                w_red   = w_onehot | w_mirror;
                w_green = ((r_scan == 3'd3) || (r_scan == 3'd4)) ? 8'hFF : 8'h18;
            end
            default: begin
                w_red   = 8'h00;
                w_green = 8'h00;
            end
        endcase
    end

    // Drive one row per clock and advance the row counter with wrap 7->0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan  <= 3'd0;
            r_hang  <= 8'hFF;
            r_red   <= 8'h00;
            r_green <= 8'h00;
        end else begin
            r_scan  <= r_scan + 3'd1;
            r_hang  <= ~w_onehot;
            r_red   <= w_red;
            r_green <= w_green;
        end
    end

    assign hang  = r_hang;
    assign red   = r_red;
    assign green = r_green;

endmodule

`default_nettype wire

// File: tb/tb_picture.sv
// ============================================================================
//  Module      : tb_picture
//  Description : Self-checking bench for the picture LED matrix driver.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_picture;

    logic       clk;
    logic       rst_n;
    logic [2:0] P;
    logic [7:0] hang;
    logic [7:0] red;
    logic [7:0] green;

    int n_chk;
    int n_fail;

    // Bench-side view of the scan position and frame-held pattern
    logic [2:0] m_scan;
    logic [2:0] m_pat;

    picture dut (
        .clk   (clk),
        .rst_n (rst_n),
        .P     (P),
        .hang  (hang),
        .red   (red),
        .green (green)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rom_red(input logic [2:0] p, input logic [2:0] r);
        case (p)
            3'd0: rom_red = 8'h00;
            3'd1: rom_red = 8'hFF;
            3'd2: rom_red = 8'h00;
            3'd3: rom_red = 8'hFF;
            3'd4: rom_red = (r == 3'd0 || r == 3'd7) ? 8'hFF : 8'h81;
            3'd5: rom_red = 8'h01 << r;
            3'd6: rom_red = r[0] ? 8'h55 : 8'hAA;
            default: rom_red = (8'h01 << r) | (8'h80 >> r);
        endcase
    endfunction

    function automatic logic [7:0] rom_grn(input logic [2:0] p, input logic [2:0] r);
        case (p)
            3'd0, 3'd1, 3'd4, 3'd5: rom_grn = 8'h00;
            3'd2, 3'd3:             rom_grn = 8'hFF;
            3'd6:                   rom_grn = r[0] ? 8'hAA : 8'h55;
            default:                rom_grn = (r == 3'd3 || r == 3'd4) ? 8'hFF : 8'h18;
        endcase
    endfunction

    // One clock edge; outputs compared against the bench's own prediction
    task automatic step(input string tag);
        logic [2:0] ep;
        logic [7:0] eh;
        logic [2:0] row;
        row = m_scan;
`ifdef PICTURE_FRAME_LATCH_EN
        ep = (m_scan == 3'd0) ? P : m_pat;
`else
        ep = P;
`endif
        eh = ~(8'h01 << row);
        @(posedge clk);
        #1;
        chk($sformatf("%s_r%0d_hang", tag, row), hang, eh);
        chk($sformatf("%s_r%0d_red", tag, row), red, rom_red(ep, row));
        chk($sformatf("%s_r%0d_green", tag, row), green, rom_grn(ep, row));
        if (m_scan == 3'd0) m_pat = P;
        m_scan = m_scan + 3'd1;
    endtask

    logic [7:0] hang_tab [8];

    initial begin
        n_chk  = 0;
        n_fail = 0;
        m_scan = 3'd0;
        m_pat  = 3'd0;
        hang_tab[0] = 8'hFE; hang_tab[1] = 8'hFD; hang_tab[2] = 8'hFB; hang_tab[3] = 8'hF7;
        hang_tab[4] = 8'hEF; hang_tab[5] = 8'hDF; hang_tab[6] = 8'hBF; hang_tab[7] = 8'h7F;

        // Reset held while clocking
        rst_n = 1'b0;
        P     = 3'd3;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_hang", hang, 8'hFF);
            chk("rst_red", red, 8'h00);
            chk("rst_green", green, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // P=3 full frame plus wrap, hang against hand table
        for (int i = 0; i < 9; i++) begin
            step("yel");
            chk($sformatf("yel_tab%0d", i), hang, hang_tab[i % 8]);
            chk("yel_red_ff", red, 8'hFF);
        end
        while (m_scan != 3'd0) step("align");

        // Mid-frame select change: rows 0-4 yellow, then P=2
        for (int i = 0; i < 5; i++) step("chg_a");
        P = 3'd2;
        step("chg_b");
`ifdef PICTURE_FRAME_LATCH_EN
        chk("chg_row5_red", red, 8'hFF);
`else
        chk("chg_row5_red", red, 8'h00);
`endif
        chk("chg_row5_green", green, 8'hFF);
        step("chg_b");
        step("chg_b");
        step("chg_c");
        chk("chg_next_row0_red", red, 8'h00);
        chk("chg_next_row0_green", green, 8'hFF);
        while (m_scan != 3'd0) step("align");

        // Spot checks from hand-worked rows
        P = 3'd6;
        step("chk6");
        chk("chk6_r0_red", red, 8'hAA);
        step("chk6");
        chk("chk6_r1_red", red, 8'h55);
        while (m_scan != 3'd0) step("chk6");
        P = 3'd7;
        for (int i = 0; i < 4; i++) step("chk7");
        chk("chk7_r3_red", red, 8'h18);
        chk("chk7_r3_green", green, 8'hFF);
        while (m_scan != 3'd0) step("chk7");
        P = 3'd5;
        for (int i = 0; i < 7; i++) step("chk5");
        chk("chk5_r6_red", red, 8'h40);
        chk("chk5_r6_green", green, 8'h00);
        while (m_scan != 3'd0) step("chk5");

        // Mid-frame asynchronous reset at row 4
        P = 3'd1;
        for (int i = 0; i < 5; i++) step("mrst");
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_async_hang", hang, 8'hFF);
        chk("mrst_async_red", red, 8'h00);
        chk("mrst_async_green", green, 8'h00);
        @(negedge clk);
        rst_n  = 1'b1;
        m_scan = 3'd0;
        m_pat  = 3'd0;
        step("mrst_rel");
        chk("mrst_rel_hang", hang, 8'hFE);
        chk("mrst_rel_red", red, 8'hFF);
        while (m_scan != 3'd0) step("align");

        // Sweep every pattern over two full frames
        for (int p = 0; p < 8; p++) begin
            P = 3'(p);
            for (int i = 0; i < 16; i++) step($sformatf("sweep_p%0d", p));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
